// File: rtl/fft_ctrl.sv
// Address and strobe sequencer for an in-place radix-2 DIT FFT with bit-reversed input order.
// Optional macro FFT_CTRL_SCALE_EN drives scale high with every butterfly read.
module fft_ctrl #(
  parameter int unsigned N_LOG2   = 5,
  parameter int unsigned BFLY_LAT = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(N_LOG2)-1:0]   stage,
  output logic                        rd_en,
  output logic [N_LOG2-1:0]           rd_addr_a,
  output logic [N_LOG2-1:0]           rd_addr_b,
  output logic [N_LOG2-2:0]           tw_addr,
  output logic                        wr_en,
  output logic [N_LOG2-1:0]           wr_addr_a,
  output logic [N_LOG2-1:0]           wr_addr_b,
  output logic                        scale
);

  localparam int unsigned NW      = N_LOG2;
  localparam int unsigned BW      = N_LOG2 - 1;
  localparam int unsigned TW      = N_LOG2 - 1;
  localparam int unsigned SW      = $clog2(N_LOG2);
  localparam int unsigned DW      = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
  localparam int unsigned HALF_M1 = (1 << (N_LOG2 - 1)) - 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic          en;
    logic [NW-1:0] a;
    logic [NW-1:0] b;
  } wr_ent_t;

  state_t        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [BW-1:0] b_q, b_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          busy_d, done_d, run_d;
  logic [NW-1:0] lo_mask, b_ext, addr_a_d, addr_b_d, tw_full;
  wr_ent_t       wr_pipe [BFLY_LAT];

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    dcnt_d  = dcnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    run_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          s_d     = '0;
          b_d     = '0;
        end
      end
      S_RUN: begin
        if (b_q == BW'(HALF_M1)) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end else begin
          b_d = b_q + BW'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DW'(BFLY_LAT - 1)) begin
          if (s_q == SW'(N_LOG2 - 1)) begin
            state_d = S_DONE;
            s_d     = '0;
          end else begin
            state_d = S_RUN;
            s_d     = s_q + SW'(1);
            b_d     = '0;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    run_d  = (state_d == S_RUN);
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // Operand pair splits b around bit s; twiddle index scales the low bits up to N/2 resolution
  always_comb begin
    lo_mask  = (NW'(1) << s_d) - NW'(1);
    b_ext    = NW'(b_d);
    addr_a_d = ((b_ext >> s_d) << (32'(s_d) + 32'd1)) | (b_ext & lo_mask);
    addr_b_d = addr_a_d | (NW'(1) << s_d);
    tw_full  = (b_ext & lo_mask) << (32'(N_LOG2 - 1) - 32'(s_d));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      s_q       <= '0;
      b_q       <= '0;
      dcnt_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stage     <= '0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      for (int i = 0; i < int'(BFLY_LAT); i++) wr_pipe[i] <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      b_q       <= b_d;
      dcnt_q    <= dcnt_d;
      busy      <= busy_d;
      done      <= done_d;
      stage     <= s_d;
      rd_en     <= run_d;
      rd_addr_a <= run_d ? addr_a_d : '0;
      rd_addr_b <= run_d ? addr_b_d : '0;
      tw_addr   <= run_d ? TW'(tw_full) : '0;
      wr_pipe[0] <= '{en: rd_en, a: rd_addr_a, b: rd_addr_b};
      for (int i = 1; i < int'(BFLY_LAT); i++) wr_pipe[i] <= wr_pipe[i-1];
    end
  end

  assign wr_en     = wr_pipe[BFLY_LAT-1].en;
  assign wr_addr_a = wr_pipe[BFLY_LAT-1].a;
  assign wr_addr_b = wr_pipe[BFLY_LAT-1].b;

`ifdef FFT_CTRL_SCALE_EN
  always_ff @(posedge clk) begin
    if (reset) scale <= 1'b0;
    else       scale <= run_d;
  end
`else
  assign scale = 1'b0;
`endif

endmodule
